// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register file and its scoreboard.
package regfile_pkg;

  function automatic int unsigned addr_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  localparam int unsigned DEF_NREGS = 32;
  localparam int unsigned DEF_AW    = addr_width(DEF_NREGS);

  typedef logic [DEF_AW-1:0] reg_addr_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking: alloc sets, writeback clears, flush clears all.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS = 32,
  localparam int unsigned AW    = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic             alloc_en,
  input  logic [AW-1:0]    alloc_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic             any_busy
);

  // Later assignment wins, so an alloc to the address being written back leaves it busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (en) begin
      if (flush) begin
        busy <= '0;
      end else begin
        if (we && waddr != '0)
          busy[waddr] <= 1'b0;
        if (alloc_en && alloc_addr != '0)
          busy[alloc_addr] <= 1'b1;
      end
    end
  end

  always_comb any_busy = |busy;

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file with writeback bypass, busy scoreboard and a
// post-reset clear sweep that gates ready.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned NRD   = 2,
  localparam int unsigned AW    = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic                any_busy
);

  state_e            state;
  logic [AW-1:0]     clr_idx;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [AW-1:0]     raddr [NRD];
  logic              run;

  always_comb run = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == AW'(NREGS - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: ;
        default: state <= CLEAR;
      endcase
    end
  end

  // The array has no reset; the sweep zeroes it before anything can read it.
  always_ff @(posedge clk) begin
    if (!run)
      regs[clr_idx] <= '0;
    else if (we && waddr != '0)
      regs[waddr] <= wdata;
  end

  reg_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .en        (run),
    .we        (we),
    .waddr     (waddr),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .flush     (flush),
    .busy      (busy),
    .any_busy  (any_busy)
  );

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      raddr[i] = ra[i*AW +: AW];
      if (run && raddr[i] != '0) begin
        if (we && waddr == raddr[i]) begin
          rdata[i*XLEN +: XLEN] = wdata;
        end else begin
          rdata[i*XLEN +: XLEN] = regs[raddr[i]];
          rbusy[i]              = busy[raddr[i]];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb (XLEN=32, NREGS=32, NRD=4).
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                ready;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                flush;
  logic                any_busy;

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] exp_q[$];

  reg_file_sb #(
    .XLEN (XLEN),
    .NREGS(32),
    .NRD  (NRD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .ra        (ra),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .flush     (flush),
    .any_busy  (any_busy)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %h, no expectation queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setra(input int p, input logic [AW-1:0] a);
    ra[p*AW +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] rd(input int p);
    return rdata[p*XLEN +: XLEN];
  endfunction

  task automatic idle();
    we = 1'b0; alloc_en = 1'b0; flush = 1'b0;
    waddr = '0; alloc_addr = '0; wdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    ra  = '0;
    idle();
    repeat (2) tick();

    push(0); chk("rst_ready", 64'(ready));
    push(0); chk("rst_any_busy", 64'(any_busy));
    push(0); chk("rst_rbusy", 64'(rbusy));

    // Writes and allocs held through the whole sweep must be dropped
    we = 1'b1; waddr = 5'd6; wdata = 32'hAAAA_AAAA;
    alloc_en = 1'b1; alloc_addr = 5'd8;
    setra(0, 5'd5);
    rst = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      tick();
      push(64'(e == 31));
      chk($sformatf("clr_ready_e%0d", e), 64'(ready));
      if (e == 3) begin
        #1;
        push(0); chk("clr_rdata_r5", 64'(rd(0)));
        push(0); chk("clr_rbusy_r5", 64'(rbusy[0]));
      end
    end
    idle();
    #1;
    push(0); chk("run_rdata_r5", 64'(rd(0)));
    push(0); chk("run_rbusy_r5", 64'(rbusy[0]));
    setra(0, 5'd6);
    #1;
    push(0); chk("clr_write_dropped_r6", 64'(rd(0)));
    push(0); chk("clr_alloc_dropped", 64'(any_busy));

    // Alloc r7, then writeback with same-cycle bypass
    alloc_en = 1'b1; alloc_addr = 5'd7;
    tick();
    idle();
    setra(0, 5'd7); setra(1, 5'd7);
    #1;
    push(1); chk("alloc_rbusy_r7", 64'(rbusy[0]));
    push(1); chk("alloc_any_busy", 64'(any_busy));
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
    #1;
    push(32'hDEAD_BEEF); chk("bypass_rdata_p0", 64'(rd(0)));
    push(32'hDEAD_BEEF); chk("bypass_rdata_p1", 64'(rd(1)));
    push(0);             chk("bypass_rbusy_p0", 64'(rbusy[0]));
    tick();
    idle();
    #1;
    push(0);             chk("wb_any_busy", 64'(any_busy));
    push(32'hDEAD_BEEF); chk("wb_rdata_r7", 64'(rd(0)));

    // Same-cycle alloc and writeback to r3: alloc wins busy
    alloc_en = 1'b1; alloc_addr = 5'd3;
    we = 1'b1; waddr = 5'd3; wdata = 32'h11;
    tick();
    idle();
    setra(0, 5'd3);
    #1;
    push(32'h11); chk("wa_rdata_r3", 64'(rd(0)));
    push(1);      chk("wa_rbusy_r3", 64'(rbusy[0]));

    // Several allocs, then flush with a concurrent alloc and write
    alloc_en = 1'b1; alloc_addr = 5'd1; tick();
    alloc_addr = 5'd2; tick();
    alloc_addr = 5'd4; tick();
    idle();
    setra(0, 5'd1); setra(1, 5'd4); setra(2, 5'd2);
    #1;
    push(4'b0111); chk("multi_rbusy", 64'(rbusy));
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd9;
    we = 1'b1; waddr = 5'd12; wdata = 32'h1234;
    tick();
    idle();
    setra(0, 5'd9); setra(1, 5'd12); setra(2, 5'd3);
    #1;
    push(0);       chk("flush_any_busy", 64'(any_busy));
    push(0);       chk("flush_rbusy_r9", 64'(rbusy[0]));
    push(0);       chk("flush_rbusy_r3", 64'(rbusy[2]));
    push(32'h1234); chk("flush_write_r12", 64'(rd(1)));

    // Register 0 stays zero and never busy, even with a write in flight
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    alloc_en = 1'b1; alloc_addr = 5'd0;
    for (int p = 0; p < NRD; p++) setra(p, 5'd0);
    #1;
    push(0); chk("r0_bypass_rdata", 64'(rdata));
    tick();
    idle();
    #1;
    push(0); chk("r0_rdata_all", 64'(rdata));
    push(0); chk("r0_rbusy_all", 64'(rbusy));
    push(0); chk("r0_any_busy", 64'(any_busy));

    // Mid-run reset: ready and busy drop without a clock edge
    we = 1'b1; waddr = 5'd10; wdata = 32'h55;
    alloc_en = 1'b1; alloc_addr = 5'd11;
    tick();
    idle();
    setra(0, 5'd10);
    #1;
    push(32'h55); chk("pre_rst_r10", 64'(rd(0)));
    push(1);      chk("pre_rst_any_busy", 64'(any_busy));
    rst = 1'b1;
    #1;
    push(0); chk("async_rst_ready", 64'(ready));
    push(0); chk("async_rst_any_busy", 64'(any_busy));
    push(0); chk("async_rst_rdata", 64'(rd(0)));
    tick();
    we = 1'b1; waddr = 5'd10; wdata = 32'h77;
    rst = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      tick();
      push(64'(e == 31));
      chk($sformatf("reclr_ready_e%0d", e), 64'(ready));
    end
    idle();
    #1;
    push(0); chk("reclr_r10", 64'(rd(0)));

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: observed %0d pending, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised architectural register file with integrated scoreboard for the decode stage. Provides NRD combinational read ports with same-cycle writeback bypass, one writeback port, and per-register busy tracking so decode can stall on pending writes. After reset, a clear sequencer zeroes the array one register per cycle and holds `ready` low until it finishes.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, architectural register count (power of two, ≥ 4); register 0 hard-wired to zero
- NRD, 2, number of read ports (1–4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ready  out  1  high once the clear sweep is complete
- ra  in  NRD×AW  read addresses (AW = clog2(NREGS))
- rdata  out  NRD×XLEN  read data
- rbusy  out  NRD  busy flag per read port
- we  in  1  writeback enable
- waddr  in  AW  writeback address
- wdata  in  XLEN  writeback data
- alloc_en  in  1  mark destination as pending
- alloc_addr  in  AW  destination being allocated
- flush  in  1  clear all busy bits
- any_busy  out  1  OR of all busy bits

## Operation
- States: CLEAR, RUN. While `rst` is high: state=CLEAR, clr_idx=1, all busy bits=0, ready=0.
- CLEAR: each edge writes 0 to regs[clr_idx] and increments clr_idx. The edge that clears NREGS-1 moves the state to RUN. `we`, `alloc_en`, and `flush` are ignored. Reads return 0 with rbusy=0.
- RUN, write: `we` && waddr≠0 → regs[waddr]←wdata and busy[waddr]←0 at the edge.
- RUN, alloc: `alloc_en` && alloc_addr≠0 → busy[alloc_addr]←1.
- Alloc and writeback to the same address in one cycle: data is written and busy ends at 1 (alloc wins).
- Flush: all busy bits←0. A concurrent `alloc_en` is ignored. A concurrent `we` still writes data.
- Read port i:
  - ra[i]=0 → rdata=0, rbusy=0.
  - else if `we` && waddr=ra[i] → rdata=wdata (bypass), rbusy=0.
  - else → rdata=regs[ra[i]], rbusy=busy[ra[i]].
  - Reads never reflect the same-cycle alloc.
- busy[0] is never set. `any_busy` is computed from registered busy bits only.
- Reset mid-operation: returns to CLEAR immediately (asynchronous) and repeats the full sweep.

## Timing
- Read path is fully combinational. Write and alloc take effect at the next rising edge.
- `ready` rises after exactly NREGS-1 rising edges following reset deassertion (31 for defaults). It stays high until the next reset.
- Reset values: ready=0, any_busy=0, busy=0. rdata and rbusy are 0 during CLEAR.
- Register contents are undefined until cleared. They are unobservable while `ready`=0.
- No back-pressure. Upstream must hold issue until `ready`=1 and must stall on rbusy.

## Structure
- Shared package `regfile_pkg`: AW localparam function, `reg_addr_t`, `state_e` {CLEAR, RUN}.
- Sub-module `reg_scoreboard`: busy vector, alloc/clear/flush priority, any_busy. Parameters NREGS; ports clk, rst, en, we, waddr, alloc_en, alloc_addr, flush, busy vector out.
- The top level holds the array, clear sequencer, and read/bypass muxes, generated per NRD.

## Test plan
- Reset release, defaults: `ready` low for 30 edges, high after edge 31. Read r5 during CLEAR → 0, rbusy=0. Read r5 after ready → 0.
- alloc r7, next cycle read r7 → rbusy=1. Then we r7 with 0xDEADBEEF: same cycle rdata=0xDEADBEEF, rbusy=0. Next cycle any_busy=0.
- Same-cycle alloc r3 and we r3 with 0x11 → next cycle rdata=0x11, rbusy=1.
- alloc r1, r2, r4 over three cycles, then flush plus alloc r9 → next cycle any_busy=0 and rbusy(r9)=0.
- we r0 with 0xFFFF_FFFF and alloc r0 → r0 reads 0, rbusy=0, any_busy=0. NRD=4 with all ports on r0 → all 0.
- Assert rst mid-RUN after writing r10=0x55 → ready drops asynchronously. After release, r10 reads 0 once ready=1. Writes during CLEAR are dropped.
